// File: rtl/systolic_sequencer_pkg.sv
// Shared encodings for the systolic instruction sequencer:
// opcodes, instruction field positions, FSM states.
package systolic_sequencer_pkg;

    localparam int INSTR_W  = 64;
    localparam int ADDR15_W = 15;
    localparam int ADDR4_W  = 4;

    localparam logic [3:0] OP_NOP      = 4'd0;
    localparam logic [3:0] OP_LOAD_INP = 4'd1;
    localparam logic [3:0] OP_LOAD_WT  = 4'd2;
    localparam logic [3:0] OP_COMPUTE  = 4'd3;
    localparam logic [3:0] OP_STORE    = 4'd4;
    localparam logic [3:0] OP_SEND     = 4'd5;
    localparam logic [3:0] OP_ACC_CLR  = 4'd6;

    localparam int OPC_HI = 63;
    localparam int OPC_LO = 60;
    localparam int A15_HI = 59;
    localparam int A15_LO = 45;
    localparam int A4_HI  = 47;
    localparam int A4_LO  = 44;
    localparam int CNT_HI = 43;
    localparam int CNT_LO = 40;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COMPUTE = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;
    localparam logic [1:0] ST_SEND    = 2'd3;

    typedef struct packed {
        logic [3:0]          op;
        logic [ADDR15_W-1:0] addr15;
        logic [ADDR4_W-1:0]  addr4;
        logic [3:0]          cnt4;
        logic [31:0]         data;
    } instr_t;

    function automatic instr_t decode(input logic [INSTR_W-1:0] w);
        instr_t r;
        r.op     = w[OPC_HI:OPC_LO];
        r.addr15 = w[A15_HI:A15_LO];
        r.addr4  = w[A4_HI:A4_LO];
        r.cnt4   = w[CNT_HI:CNT_LO];
        r.data   = w[31:0];
        return r;
    endfunction

endpackage

// File: rtl/systolic_sequencer_if.sv
// Instruction-buffer handshake between the buffer (master)
// and the sequencer (slave).
interface systolic_sequencer_if;
    import systolic_sequencer_pkg::*;

    logic               instr_valid;
    logic [INSTR_W-1:0] instr;
    logic               instr_ready;

    modport master (
        output instr_valid,
        output instr,
        input  instr_ready
    );

    modport slave (
        input  instr_valid,
        input  instr,
        output instr_ready
    );

endinterface

// File: rtl/systolic_sequencer_seq_counter.sv
// Loadable down-counter with done flag and an up-running index,
// shared by the COMPUTE, DRAIN and SEND phases.
module seq_counter #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] len,
    output logic         done,
    output logic [W-1:0] idx
);

    logic [W-1:0] cnt;

    // cnt holds the cycles remaining after the current one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (load) begin
            cnt <= len - W'(1);
            idx <= '0;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - W'(1);
            idx <= idx + W'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/systolic_sequencer.sv
// Single-issue instruction sequencer driving buffer loads,
// the systolic compute window, accumulator drain and output send.
module systolic_sequencer
    import systolic_sequencer_pkg::*;
#(
    parameter int ARR_SIZE = 4,
    parameter int K_W      = 16
) (
    input  logic                clk,
    input  logic                rst,
    systolic_sequencer_if.slave ib,
    output logic                inp_buf_we,
    output logic [ADDR15_W-1:0] inp_buf_addr,
    output logic [31:0]         inp_buf_data,
    output logic                wt_buf_we,
    output logic [ADDR15_W-1:0] wt_buf_addr,
    output logic [31:0]         wt_buf_data,
    output logic                mac_en,
    output logic [K_W-1:0]      mac_step,
    output logic                acc_store,
    output logic [ADDR4_W-1:0]  acc_op_addr,
    output logic                acc_reset,
    output logic                op_buf_send,
    output logic [ADDR4_W-1:0]  op_buf_addr,
    output logic                busy,
    output logic                err_illegal
);

    localparam int CW = K_W + 1;

    logic [1:0]     state;
    instr_t         d;
    logic [K_W-1:0] k_in;
    logic [K_W-1:0] k_last;
    logic           accept;
    logic           ctr_load;
    logic           ctr_done;
    logic [CW-1:0]  ctr_len;
    logic [CW-1:0]  ctr_idx;
    logic [CW-1:0]  step_nxt;

    assign d      = decode(ib.instr);
    assign k_in   = ib.instr[K_W-1:0];
    assign accept = ib.instr_valid && ib.instr_ready;
    assign busy   = (state != ST_IDLE);

    assign ib.instr_ready = (state == ST_IDLE) && !rst;

    // Phase lengths; DRAIN has one extra cycle for the acc_reset pulse
    always_comb begin
        ctr_load = 1'b0;
        ctr_len  = '0;
        if (accept) begin
            unique case (1'b1)
                (d.op == OP_COMPUTE) && (k_in != '0): begin
                    ctr_load = 1'b1;
                    ctr_len  = CW'(k_in) + CW'(2 * ARR_SIZE - 2);
                end
                (d.op == OP_STORE): begin
                    ctr_load = 1'b1;
                    ctr_len  = CW'(ARR_SIZE + 1);
                end
                (d.op == OP_SEND): begin
                    ctr_load = 1'b1;
                    ctr_len  = CW'(d.cnt4) + CW'(1);
                end
                default: ;
            endcase
        end
    end

    seq_counter #(.W(CW)) u_ctr (
        .clk  (clk),
        .rst  (rst),
        .load (ctr_load),
        .en   (busy),
        .len  (ctr_len),
        .done (ctr_done),
        .idx  (ctr_idx)
    );

    assign step_nxt = ctr_idx + CW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            k_last       <= '0;
            inp_buf_we   <= 1'b0;
            inp_buf_addr <= '0;
            inp_buf_data <= '0;
            wt_buf_we    <= 1'b0;
            wt_buf_addr  <= '0;
            wt_buf_data  <= '0;
            mac_en       <= 1'b0;
            mac_step     <= '0;
            acc_store    <= 1'b0;
            acc_op_addr  <= '0;
            acc_reset    <= 1'b0;
            op_buf_send  <= 1'b0;
            op_buf_addr  <= '0;
            err_illegal  <= 1'b0;
        end else begin
            inp_buf_we <= 1'b0;
            wt_buf_we  <= 1'b0;
            acc_reset  <= 1'b0;
            case (state)
                ST_IDLE: if (accept) begin
                    case (d.op)
                        OP_NOP: ;
                        OP_LOAD_INP: begin
                            inp_buf_we   <= 1'b1;
                            inp_buf_addr <= d.addr15;
                            inp_buf_data <= d.data;
                        end
                        OP_LOAD_WT: begin
                            wt_buf_we   <= 1'b1;
                            wt_buf_addr <= d.addr15;
                            wt_buf_data <= d.data;
                        end
                        OP_COMPUTE: if (k_in != '0) begin
                            state    <= ST_COMPUTE;
                            mac_en   <= 1'b1;
                            mac_step <= '0;
                            k_last   <= k_in - K_W'(1);
                        end
                        OP_STORE: begin
                            state       <= ST_DRAIN;
                            acc_store   <= 1'b1;
                            acc_op_addr <= d.addr4;
                        end
                        OP_SEND: begin
                            state       <= ST_SEND;
                            op_buf_send <= 1'b1;
                            op_buf_addr <= d.addr4;
                        end
                        OP_ACC_CLR: acc_reset <= 1'b1;
                        default:    err_illegal <= 1'b1;
                    endcase
                end
                ST_COMPUTE: begin
                    if (ctr_done) begin
                        state    <= ST_IDLE;
                        mac_en   <= 1'b0;
                        mac_step <= '0;
                    end else if (step_nxt <= {1'b0, k_last}) begin
                        mac_step <= step_nxt[K_W-1:0];
                    end else begin
                        mac_step <= k_last;
                    end
                end
                ST_DRAIN: begin
                    if (ctr_done) begin
                        state       <= ST_IDLE;
                        acc_op_addr <= '0;
                    end else if (ctr_idx == CW'(ARR_SIZE - 1)) begin
                        acc_store <= 1'b0;
                        acc_reset <= 1'b1;
                    end else begin
                        acc_op_addr <= acc_op_addr + 4'd1;
                    end
                end
                ST_SEND: begin
                    if (ctr_done) begin
                        state       <= ST_IDLE;
                        op_buf_send <= 1'b0;
                        op_buf_addr <= '0;
                    end else begin
                        op_buf_addr <= op_buf_addr + 4'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_sequencer.sv
// Bench for systolic_sequencer: vector table, directed sequences
// and a random program checked against a cycle-timeline model.
module tb_systolic_sequencer;

    localparam int A    = 4;
    localparam int KW   = 16;
    localparam int MAXC = 4096;

    typedef struct packed {
        logic        ready, busy, err, iwe, wwe, mac, ast, ars, snd;
        logic [14:0] iad, wad;
        logic [31:0] idt, wdt;
        logic [15:0] stp;
        logic [3:0]  aad, oad;
    } exp_t;

    typedef struct {
        logic [63:0] w;
        exp_t        x;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inp_buf_we, wt_buf_we, mac_en, acc_store;
    logic        acc_reset, op_buf_send, busy, err_illegal;
    logic [14:0] inp_buf_addr, wt_buf_addr;
    logic [31:0] inp_buf_data, wt_buf_data;
    logic [15:0] mac_step;
    logic [3:0]  acc_op_addr, op_buf_addr;

    int checks = 0;
    int fails  = 0;

    exp_t        e[MAXC];
    logic [63:0] q[$];
    vec_t        vt[$];

    systolic_sequencer_if ib();

    always #5 clk = ~clk;

    systolic_sequencer #(.ARR_SIZE(A), .K_W(KW)) dut (
        .clk          (clk),
        .rst          (rst),
        .ib           (ib),
        .inp_buf_we   (inp_buf_we),
        .inp_buf_addr (inp_buf_addr),
        .inp_buf_data (inp_buf_data),
        .wt_buf_we    (wt_buf_we),
        .wt_buf_addr  (wt_buf_addr),
        .wt_buf_data  (wt_buf_data),
        .mac_en       (mac_en),
        .mac_step     (mac_step),
        .acc_store    (acc_store),
        .acc_op_addr  (acc_op_addr),
        .acc_reset    (acc_reset),
        .op_buf_send  (op_buf_send),
        .op_buf_addr  (op_buf_addr),
        .busy         (busy),
        .err_illegal  (err_illegal)
    );

    function automatic logic [63:0] w_a15(int op, int a15, logic [31:0] dat);
        logic [63:0] w;
        w = '0;
        w[63:60] = 4'(op);
        w[59:45] = 15'(a15);
        w[31:0]  = dat;
        return w;
    endfunction

    function automatic logic [63:0] w_a4(int op, int a4, int c4);
        logic [63:0] w;
        w = '0;
        w[63:60] = 4'(op);
        w[47:44] = 4'(a4);
        w[43:40] = 4'(c4);
        return w;
    endfunction

    function automatic logic [63:0] w_k(int k);
        logic [63:0] w;
        w = '0;
        w[63:60] = 4'd3;
        w[15:0]  = 16'(k);
        return w;
    endfunction

    // Address/data fields are only meaningful while their strobe is high
    function automatic exp_t sample();
        exp_t s;
        s = '0;
        s.ready = ib.instr_ready;
        s.busy  = busy;
        s.err   = err_illegal;
        s.iwe   = inp_buf_we;
        s.wwe   = wt_buf_we;
        s.mac   = mac_en;
        s.ast   = acc_store;
        s.ars   = acc_reset;
        s.snd   = op_buf_send;
        if (inp_buf_we) begin
            s.iad = inp_buf_addr;
            s.idt = inp_buf_data;
        end
        if (wt_buf_we) begin
            s.wad = wt_buf_addr;
            s.wdt = wt_buf_data;
        end
        if (mac_en)      s.stp = mac_step;
        if (acc_store)   s.aad = acc_op_addr;
        if (op_buf_send) s.oad = op_buf_addr;
        return s;
    endfunction

    task automatic cmp(input string nm, input exp_t x);
        exp_t s;
        s = sample();
        checks++;
        if (s !== x) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, s, x);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic exp_t mkx(logic iwe, logic wwe, logic ars,
                                 logic err, int a15, logic [31:0] dat);
        exp_t x;
        x = '0;
        x.ready = 1'b1;
        x.err   = err;
        x.iwe   = iwe;
        x.wwe   = wwe;
        x.ars   = ars;
        if (iwe) begin
            x.iad = 15'(a15);
            x.idt = dat;
        end
        if (wwe) begin
            x.wad = 15'(a15);
            x.wdt = dat;
        end
        return x;
    endfunction

    task automatic do_reset();
        exp_t x;
        ib.instr_valid = 1'b0;
        ib.instr       = '0;
        rst = 1'b1;
        #1 cmp("in_reset", '0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        x = '0;
        x.ready = 1'b1;
        cmp("after_reset", x);
    endtask

    // Expected timeline: instruction j is accepted on the first idle
    // cycle after j-1, its effects appear from the following cycle.
    task automatic run_prog(input string tag, input logic [63:0] p[$],
                            output int macs);
        int t, errc, total, j, n, l;
        int op, a15, a4, c4, k;
        logic [31:0] dat;
        t = 0;
        errc = -1;
        for (int c = 0; c < MAXC; c++) e[c] = '0;
        foreach (p[i]) begin
            op  = int'(p[i][63:60]);
            a15 = int'(p[i][59:45]);
            a4  = int'(p[i][47:44]);
            c4  = int'(p[i][43:40]);
            k   = int'(p[i][15:0]);
            dat = p[i][31:0];
            case (op)
                1: begin
                    e[t+1].iwe = 1'b1;
                    e[t+1].iad = 15'(a15);
                    e[t+1].idt = dat;
                    t += 1;
                end
                2: begin
                    e[t+1].wwe = 1'b1;
                    e[t+1].wad = 15'(a15);
                    e[t+1].wdt = dat;
                    t += 1;
                end
                3: if (k == 0) t += 1;
                else begin
                    l = k + 2 * A - 2;
                    for (int i = 0; i < l; i++) begin
                        e[t+1+i].mac  = 1'b1;
                        e[t+1+i].busy = 1'b1;
                        e[t+1+i].stp  = 16'((i < k) ? i : k - 1);
                    end
                    t += l + 1;
                end
                4: begin
                    for (int i = 0; i < A; i++) begin
                        e[t+1+i].ast  = 1'b1;
                        e[t+1+i].busy = 1'b1;
                        e[t+1+i].aad  = 4'(a4 + i);
                    end
                    e[t+1+A].ars  = 1'b1;
                    e[t+1+A].busy = 1'b1;
                    t += A + 2;
                end
                5: begin
                    for (int i = 0; i <= c4; i++) begin
                        e[t+1+i].snd  = 1'b1;
                        e[t+1+i].busy = 1'b1;
                        e[t+1+i].oad  = 4'(a4 + i);
                    end
                    t += c4 + 2;
                end
                6: begin
                    e[t+1].ars = 1'b1;
                    t += 1;
                end
                0: t += 1;
                default: begin
                    if (errc < 0) errc = t + 1;
                    t += 1;
                end
            endcase
        end
        total = t + 4;
        for (int c = 0; c < total; c++) begin
            e[c].ready = !e[c].busy;
            e[c].err   = (errc >= 0) && (c >= errc);
        end
        j = 0;
        n = p.size();
        macs = 0;
        for (int c = 0; c < total; c++) begin
            ib.instr_valid = (j < n);
            ib.instr       = (j < n) ? p[j] : 64'd0;
            @(negedge clk);
            cmp($sformatf("%s c%0d", tag, c), e[c]);
            if (mac_en) macs++;
            @(posedge clk); #1;
            if (e[c].ready && (j < n)) j++;
        end
        ib.instr_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_t x, x2;
        int m, r, op, sends;
        logic [63:0] w;

        ib.instr_valid = 1'b0;
        ib.instr       = '0;
        do_reset();

        vt.push_back('{w_a15(1, 16'h0010, 32'hDEADBEEF),
                       mkx(1, 0, 0, 0, 16'h0010, 32'hDEADBEEF)});
        vt.push_back('{w_a15(2, 16'h7FFF, 32'h1),
                       mkx(0, 1, 0, 0, 16'h7FFF, 32'h1)});
        vt.push_back('{w_a15(0, 5, 32'h55), mkx(0, 0, 0, 0, 0, 0)});
        vt.push_back('{w_a15(6, 0, 0), mkx(0, 0, 1, 0, 0, 0)});
        vt.push_back('{w_k(0), mkx(0, 0, 0, 0, 0, 0)});
        vt.push_back('{w_a15(1, 0, 0), mkx(1, 0, 0, 0, 0, 0)});
        vt.push_back('{w_a15(7, 3, 32'h9), mkx(0, 0, 0, 1, 0, 0)});
        vt.push_back('{w_a15(2, 16'h1234, 32'hCAFEF00D),
                       mkx(0, 1, 0, 1, 16'h1234, 32'hCAFEF00D)});
        vt.push_back('{w_a15(15, 1, 32'h1), mkx(0, 0, 0, 1, 0, 0)});

        foreach (vt[i]) begin
            ib.instr_valid = 1'b1;
            ib.instr       = vt[i].w;
            @(posedge clk); #1;
            ib.instr_valid = 1'b0;
            @(negedge clk);
            cmp($sformatf("vec%0d", i), vt[i].x);
            x2 = vt[i].x;
            x2.iwe = 1'b0; x2.wwe = 1'b0; x2.ars = 1'b0;
            x2.iad = '0;   x2.idt = '0;
            x2.wad = '0;   x2.wdt = '0;
            @(posedge clk); #1;
            @(negedge clk);
            cmp($sformatf("vec%0d_after", i), x2);
            @(posedge clk); #1;
        end

        // Reset in the third cycle of an 8-entry SEND
        do_reset();
        ib.instr_valid = 1'b1;
        ib.instr       = w_a4(5, 0, 7);
        @(posedge clk); #1;
        ib.instr_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        x = '0;
        x.busy = 1'b1;
        x.snd  = 1'b1;
        x.oad  = 4'd2;
        cmp("send_c3", x);
        #1 rst = 1'b1;
        #1 cmp("rst_abort", '0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        x = '0;
        x.ready = 1'b1;
        cmp("rst_release", x);
        sends = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (op_buf_send) sends++;
        end
        chk_int("no_send_after_rst", sends, 0);
        @(posedge clk); #1;

        q.delete();
        q.push_back(w_a15(1, 16'h0010, 32'hDEADBEEF));
        q.push_back(w_a15(2, 16'h7FFF, 32'h1));
        run_prog("b2b_load", q, m);

        q.delete();
        q.push_back(w_k(5));
        q.push_back(w_a15(1, 3, 32'h3));
        run_prog("compute5", q, m);
        chk_int("compute5_mac_cycles", m, 11);

        q.delete();
        q.push_back(w_k(0));
        q.push_back(w_a15(0, 0, 0));
        run_prog("compute0", q, m);
        chk_int("compute0_mac_cycles", m, 0);

        q.delete();
        q.push_back(w_a4(4, 14, 0));
        run_prog("store14", q, m);

        q.delete();
        q.push_back(w_a4(5, 3, 2));
        q.push_back(w_k(2));
        run_prog("send3", q, m);

        q.delete();
        q.push_back(w_a15(15, 0, 0));
        q.push_back(w_a15(6, 0, 0));
        run_prog("illegal_clr", q, m);

        do_reset();
        q.delete();
        for (int i = 0; i < 30; i++) begin
            r  = $urandom_range(0, 15);
            op = (r < 14) ? (r % 7) : 8 + $urandom_range(0, 7);
            w  = {$urandom, $urandom};
            w[63:60] = 4'(op);
            if (op == 3) w[15:0] = 16'($urandom_range(0, 12));
            q.push_back(w);
        end
        run_prog("random", q, m);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
